// File: rtl/pre_mem_stage_pkg.sv
// Shared widths, bus layouts and helpers for the pre-memory stage.
package pre_mem_stage_pkg;

    // Bus widths: per instruction 116 bits in, 113 bits out, 39 bits forwarded.
    localparam int ES_TO_PMS_BUS_WD   = 233;
    localparam int PMS_TO_MS_BUS_WD   = 227;
    localparam int PMS_FORWARD_BUS_WD = 79;

    // Bit positions inside store_type {sb,sh,sw,swl,swr}.
    localparam int ST_SB  = 4;
    localparam int ST_SH  = 3;
    localparam int ST_SW  = 2;
    localparam int ST_SWL = 1;
    localparam int ST_SWR = 0;

    // Bit positions inside load_type {lb,lbu,lh,lhu,lw,lwl,lwr}.
    localparam int LT_LB  = 6;
    localparam int LT_LBU = 5;
    localparam int LT_LH  = 4;
    localparam int LT_LHU = 3;
    localparam int LT_LW  = 2;
    localparam int LT_LWL = 1;
    localparam int LT_LWR = 0;

    localparam logic [1:0] SIZE_WORD = 2'd2;

    // One instruction as delivered by EX (MSB first).
    typedef struct packed {
        logic [4:0]  store_type;
        logic [6:0]  load_type;
        logic        res_from_mem;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] rt_value;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_inst_t;

    // Whole group from EX: slot 2 above slot 1.
    typedef struct packed {
        logic     inst2_valid;
        es_inst_t inst2;
        es_inst_t inst1;
    } es_bus_t;

    // An instruction talks to the data cache if it loads or stores.
    function automatic logic needs_cache(input logic res_from_mem, input logic mem_we);
        return res_from_mem | mem_we;
    endfunction

endpackage

// File: rtl/pre_mem_stage_store_align.sv
// Byte strobes and lane-shifted write data for one store slot.
module pre_mem_stage_store_align
    import pre_mem_stage_pkg::*;
(
    input  logic [4:0]  store_type_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rt_value_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    // Select lanes and place the register bytes for the store kind.
    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = rt_value_i;
        if (store_type_i[ST_SB]) begin
            wstrb_o = 4'b0001 << offset_i;
            wdata_o = {4{rt_value_i[7:0]}};
        end else if (store_type_i[ST_SH]) begin
            wstrb_o = offset_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{rt_value_i[15:0]}};
        end else if (store_type_i[ST_SW]) begin
            wstrb_o = 4'b1111;
            wdata_o = rt_value_i;
        end else if (store_type_i[ST_SWL]) begin
            // Upper register bytes land in the low lanes up to the offset.
            case (offset_i)
                2'd0:    begin wstrb_o = 4'b0001; wdata_o = {24'h000000, rt_value_i[31:24]}; end
                2'd1:    begin wstrb_o = 4'b0011; wdata_o = {16'h0000, rt_value_i[31:16]}; end
                2'd2:    begin wstrb_o = 4'b0111; wdata_o = {8'h00, rt_value_i[31:8]}; end
                default: begin wstrb_o = 4'b1111; wdata_o = rt_value_i; end
            endcase
        end else if (store_type_i[ST_SWR]) begin
            // Lower register bytes land from the offset lane upwards.
            case (offset_i)
                2'd0:    begin wstrb_o = 4'b1111; wdata_o = rt_value_i; end
                2'd1:    begin wstrb_o = 4'b1110; wdata_o = {rt_value_i[23:0], 8'h00}; end
                2'd2:    begin wstrb_o = 4'b1100; wdata_o = {rt_value_i[15:0], 16'h0000}; end
                default: begin wstrb_o = 4'b1000; wdata_o = {rt_value_i[7:0], 24'h000000}; end
            endcase
        end else begin
            wstrb_o = 4'b0000;
            wdata_o = rt_value_i;
        end
    end

endmodule

// File: rtl/pre_mem_stage.sv
// Dual-issue stage between EX and MEM: holds the group until every cache
// request it needs has been accepted, then hands it to MEM.
module pre_mem_stage
    import pre_mem_stage_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          es_to_pms_valid,
    input  logic [ES_TO_PMS_BUS_WD-1:0]   es_to_pms_bus,
    output logic                          pms_allowin,
    input  logic                          ms_allowin,
    output logic                          pms_to_ms_valid,
    output logic [PMS_TO_MS_BUS_WD-1:0]   pms_to_ms_bus,
    output logic [PMS_FORWARD_BUS_WD-1:0] pms_forward_bus,
    output logic                          data_cache_valid_01,
    output logic                          data_cache_op_01,
    output logic [1:0]                    data_cache_size_01,
    output logic [3:0]                    data_cache_wstrb_01,
    output logic [31:0]                   data_cache_addr_01,
    output logic [31:0]                   data_cache_wdata_01,
    input  logic                          data_cache_addr_ok_01,
    output logic                          data_cache_valid_02,
    output logic                          data_cache_op_02,
    output logic [1:0]                    data_cache_size_02,
    output logic [3:0]                    data_cache_wstrb_02,
    output logic [31:0]                   data_cache_addr_02,
    output logic [31:0]                   data_cache_wdata_02,
    input  logic                          data_cache_addr_ok_02
);

    logic    pms_valid_q, pms_valid_d;
    es_bus_t bus_q, bus_d;
    es_bus_t in_bus_s;
    logic    need_1_s, need_2_s, ready_go_s, req_en_s;
    logic [3:0]  align_wstrb_1_s, align_wstrb_2_s;
    logic [31:0] align_wdata_1_s, align_wdata_2_s;

    assign in_bus_s = es_bus_t'(es_to_pms_bus);

    // Next-state for the valid flag and the held group.
    always_comb begin
        pms_valid_d = pms_valid_q;
        bus_d       = bus_q;
        if (pms_allowin) begin
            pms_valid_d = es_to_pms_valid;
        end else begin
            pms_valid_d = pms_valid_q;
        end
        if (es_to_pms_valid && pms_allowin) begin
            bus_d = in_bus_s;
        end else begin
            bus_d = bus_q;
        end
    end

    // Valid flag register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pms_valid_q <= 1'b0;
        end else begin
            pms_valid_q <= pms_valid_d;
        end
    end

    // Group payload register; contents are meaningless while invalid.
    always_ff @(posedge clk) begin
        bus_q <= bus_d;
    end

    // Handshake: a slot without a cache access never holds the group back.
    always_comb begin
        need_1_s   = pms_valid_q & needs_cache(bus_q.inst1.res_from_mem, bus_q.inst1.mem_we);
        need_2_s   = pms_valid_q & bus_q.inst2_valid
                   & needs_cache(bus_q.inst2.res_from_mem, bus_q.inst2.mem_we);
        ready_go_s = (~need_1_s | data_cache_addr_ok_01) & (~need_2_s | data_cache_addr_ok_02);
        // Requests only go out when MEM can take the group, so data_ok finds it there.
        req_en_s   = ms_allowin & ~reset;
        pms_allowin     = ~pms_valid_q | (ready_go_s & ms_allowin);
        pms_to_ms_valid = pms_valid_q & ready_go_s;
    end

    pre_mem_stage_store_align u_align_1 (
        .store_type_i (bus_q.inst1.store_type),
        .offset_i     (bus_q.inst1.alu_result[1:0]),
        .rt_value_i   (bus_q.inst1.rt_value),
        .wstrb_o      (align_wstrb_1_s),
        .wdata_o      (align_wdata_1_s)
    );

    pre_mem_stage_store_align u_align_2 (
        .store_type_i (bus_q.inst2.store_type),
        .offset_i     (bus_q.inst2.alu_result[1:0]),
        .rt_value_i   (bus_q.inst2.rt_value),
        .wstrb_o      (align_wstrb_2_s),
        .wdata_o      (align_wdata_2_s)
    );

    assign data_cache_valid_01 = need_1_s & req_en_s;
    assign data_cache_op_01    = bus_q.inst1.mem_we;
    assign data_cache_size_01  = SIZE_WORD;
    assign data_cache_wstrb_01 = bus_q.inst1.mem_we ? align_wstrb_1_s : 4'b0000;
    assign data_cache_addr_01  = {bus_q.inst1.alu_result[31:2], 2'b00};
    assign data_cache_wdata_01 = align_wdata_1_s;

    assign data_cache_valid_02 = need_2_s & req_en_s;
    assign data_cache_op_02    = bus_q.inst2.mem_we;
    assign data_cache_size_02  = SIZE_WORD;
    assign data_cache_wstrb_02 = bus_q.inst2.mem_we ? align_wstrb_2_s : 4'b0000;
    assign data_cache_addr_02  = {bus_q.inst2.alu_result[31:2], 2'b00};
    assign data_cache_wdata_02 = align_wdata_2_s;

    assign pms_to_ms_bus = {
        bus_q.inst2_valid,
        bus_q.inst2.load_type, bus_q.inst2.alu_result[1:0], bus_q.inst2.res_from_mem,
        bus_q.inst2.mem_we, bus_q.inst2.gr_we, bus_q.inst2.dest, bus_q.inst2.rt_value,
        bus_q.inst2.alu_result, bus_q.inst2.pc,
        bus_q.inst1.load_type, bus_q.inst1.alu_result[1:0], bus_q.inst1.res_from_mem,
        bus_q.inst1.mem_we, bus_q.inst1.gr_we, bus_q.inst1.dest, bus_q.inst1.rt_value,
        bus_q.inst1.alu_result, bus_q.inst1.pc
    };

    assign pms_forward_bus = {
        pms_valid_q,
        bus_q.inst1.res_from_mem, bus_q.inst1.gr_we, bus_q.inst1.dest, bus_q.inst1.alu_result,
        bus_q.inst2.res_from_mem, bus_q.inst2.gr_we, bus_q.inst2.dest, bus_q.inst2.alu_result
    };

endmodule

// File: tb/tb_pre_mem_stage.sv
// Randomized bench for pre_mem_stage with a queue-based reference model.
module tb_pre_mem_stage;
    import pre_mem_stage_pkg::*;

    typedef struct {
        logic [4:0]  st;
        logic [6:0]  lt;
        logic        rfm;
        logic        we;
        logic        gwe;
        logic [4:0]  dest;
        logic [31:0] rt;
        logic [31:0] alu;
        logic [31:0] pc;
    } inst_t;

    typedef struct {
        inst_t a;
        inst_t b;
        logic  v2;
    } grp_t;

    logic clk = 1'b0;
    logic reset;
    logic es_valid;
    logic [ES_TO_PMS_BUS_WD-1:0] es_bus;
    logic pms_allowin, ms_allowin, pms_to_ms_valid;
    logic [PMS_TO_MS_BUS_WD-1:0]   ms_bus;
    logic [PMS_FORWARD_BUS_WD-1:0] fwd_bus;
    logic v01, op01, v02, op02, ok01, ok02;
    logic [1:0]  sz01, sz02;
    logic [3:0]  st01, st02;
    logic [31:0] ad01, ad02, wd01, wd02;

    int   n_chk = 0;
    int   n_pass = 0;
    int   ok_mode = 1;   // 0 random, 1 accept, 2 refuse
    grp_t cur_g;
    grp_t q[$];
    logic m_has, m_rdy, m_alw;

    always #5 clk = ~clk;

    pre_mem_stage dut (
        .clk(clk), .reset(reset), .es_to_pms_valid(es_valid), .es_to_pms_bus(es_bus),
        .pms_allowin(pms_allowin), .ms_allowin(ms_allowin), .pms_to_ms_valid(pms_to_ms_valid),
        .pms_to_ms_bus(ms_bus), .pms_forward_bus(fwd_bus),
        .data_cache_valid_01(v01), .data_cache_op_01(op01), .data_cache_size_01(sz01),
        .data_cache_wstrb_01(st01), .data_cache_addr_01(ad01), .data_cache_wdata_01(wd01),
        .data_cache_addr_ok_01(ok01),
        .data_cache_valid_02(v02), .data_cache_op_02(op02), .data_cache_size_02(sz02),
        .data_cache_wstrb_02(st02), .data_cache_addr_02(ad02), .data_cache_wdata_02(wd02),
        .data_cache_addr_ok_02(ok02)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [115:0] pk_in(input inst_t i);
        return {i.st, i.lt, i.rfm, i.we, i.gwe, i.dest, i.rt, i.alu, i.pc};
    endfunction

    function automatic logic [112:0] pk_out(input inst_t i);
        logic [1:0] k;
        k = i.alu[1:0];
        return {i.lt, k, i.rfm, i.we, i.gwe, i.dest, i.rt, i.alu, i.pc};
    endfunction

    function automatic logic [38:0] pk_fwd(input inst_t i);
        return {i.rfm, i.gwe, i.dest, i.alu};
    endfunction

    // Byte lanes written, described by which lanes the store touches.
    function automatic logic [3:0] exp_strb(input inst_t i);
        logic [3:0] m;
        int k;
        m = 4'b0000;
        k = int'(i.alu[1:0]);
        if (!i.we) return 4'b0000;
        for (int j = 0; j < 4; j++) begin
            if (i.st[4])      m[j] = (j == k);
            else if (i.st[3]) m[j] = (j / 2 == k / 2);
            else if (i.st[2]) m[j] = 1'b1;
            else if (i.st[1]) m[j] = (j <= k);
            else if (i.st[0]) m[j] = (j >= k);
            else              m[j] = 1'b0;
        end
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input inst_t i);
        int k;
        k = int'(i.alu[1:0]);
        if (i.st[4]) return {4{i.rt[7:0]}};
        if (i.st[3]) return {2{i.rt[15:0]}};
        if (i.st[1]) return i.rt >> (8 * (3 - k));
        if (i.st[0]) return i.rt << (8 * k);
        return i.rt;
    endfunction

    function automatic inst_t mk(input logic [4:0] st, input logic [6:0] lt,
                                 input logic [31:0] alu, input logic [31:0] rt);
        inst_t i;
        i.st = st; i.lt = lt; i.rfm = |lt; i.we = |st; i.gwe = |lt;
        i.dest = 5'd3; i.rt = rt; i.alu = alu; i.pc = 32'hBFC0_0100;
        return i;
    endfunction

    function automatic inst_t rnd_inst();
        inst_t i;
        int kind;
        kind = $urandom_range(0, 2);
        i = mk(5'b00000, 7'b0000000, $urandom, $urandom);
        i.pc = $urandom;
        i.dest = 5'($urandom_range(0, 31));
        if (kind == 1) begin
            i.lt = 7'b0000001 << $urandom_range(0, 6);
            i.rfm = 1'b1; i.gwe = 1'b1;
        end else if (kind == 2) begin
            i.st = 5'b00001 << $urandom_range(0, 4);
            i.we = 1'b1;
        end else begin
            i.gwe = 1'($urandom_range(0, 1));
        end
        return i;
    endfunction

    task automatic drive(input grp_t g, input logic v);
        cur_g    = g;
        es_valid = v;
        es_bus   = {g.v2, pk_in(g.b), pk_in(g.a)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cache side: answers both requests with one decision, 2 time units after the edge.
    initial begin
        logic d;
        ok01 = 1'b0;
        ok02 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ok_mode == 1)      d = 1'b1;
            else if (ok_mode == 2) d = 1'b0;
            else                   d = ($urandom_range(0, 2) != 0);
            ok01 = v01 & d;
            ok02 = v02 & d;
        end
    end

    // Compare process: check outputs at the falling edge, advance the model at the rising edge.
    initial begin
        grp_t g;
        logic n1, n2, e1, e2;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_valid_01", v01, 1'b0);
                chk("rst_valid_02", v02, 1'b0);
            end else begin
                m_has = (q.size() > 0);
                if (m_has) g = q[0];
                else g = cur_g;
                n1 = m_has && (g.a.rfm || g.a.we);
                n2 = m_has && g.v2 && (g.b.rfm || g.b.we);
                e1 = n1 && ms_allowin;
                e2 = n2 && ms_allowin;
                m_rdy = (!n1 || ok01) && (!n2 || ok02);
                m_alw = !m_has || (m_rdy && ms_allowin);
                chk("valid_01", v01, e1);
                chk("valid_02", v02, e2);
                chk("allowin", pms_allowin, m_alw);
                chk("to_ms_valid", pms_to_ms_valid, m_has && m_rdy);
                chk("fwd_valid", fwd_bus[78], m_has);
                if (e1) begin
                    chk("op_01", op01, g.a.we);
                    chk("size_01", sz01, 2'd2);
                    chk("wstrb_01", st01, exp_strb(g.a));
                    chk("addr_01", ad01, {g.a.alu[31:2], 2'b00});
                    if (g.a.we) chk("wdata_01", wd01, exp_wdata(g.a));
                end
                if (e2) begin
                    chk("op_02", op02, g.b.we);
                    chk("size_02", sz02, 2'd2);
                    chk("wstrb_02", st02, exp_strb(g.b));
                    chk("addr_02", ad02, {g.b.alu[31:2], 2'b00});
                    if (g.b.we) chk("wdata_02", wd02, exp_wdata(g.b));
                end
                if (m_has) begin
                    chk("fwd_bus", fwd_bus, {1'b1, pk_fwd(g.a), pk_fwd(g.b)});
                    if (m_rdy) chk("ms_bus", ms_bus, {g.v2, pk_out(g.b), pk_out(g.a)});
                end
            end
            @(posedge clk);
            if (reset) begin
                q.delete();
            end else begin
                if (m_has && m_rdy && ms_allowin) void'(q.pop_front());
                if (m_alw && es_valid) q.push_back(cur_g);
            end
        end
    end

    // Stimulus: directed scenarios with literal expectations, then random traffic.
    initial begin
        grp_t g, idle;
        inst_t nop;
        nop = mk(5'b00000, 7'b0000000, 32'h0, 32'h0);
        idle.a = nop; idle.b = nop; idle.v2 = 1'b0;
        reset = 1'b1; ms_allowin = 1'b1; ok_mode = 1;
        drive(idle, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        #3;
        chk("lit_rst_allowin", pms_allowin, 1'b1);
        chk("lit_rst_tv", pms_to_ms_valid, 1'b0);
        chk("lit_rst_v01", v01, 1'b0);
        chk("lit_rst_fwd", fwd_bus[78], 1'b0);

        // sw at 0x1000 accepted at once
        tick();
        g = idle; g.a = mk(5'b00100, 7'b0, 32'h0000_1000, 32'hAABB_CCDD);
        drive(g, 1'b1);
        tick(); drive(idle, 1'b0); #3;
        chk("lit_sw_valid", v01, 1'b1);
        chk("lit_sw_addr", ad01, 32'h0000_1000);
        chk("lit_sw_wstrb", st01, 4'b1111);
        chk("lit_sw_wdata", wd01, 32'hAABB_CCDD);
        chk("lit_sw_tv", pms_to_ms_valid, 1'b1);
        tick(); #3;
        chk("lit_sw_gone", pms_to_ms_valid, 1'b0);
        chk("lit_sw_allowin", pms_allowin, 1'b1);

        // swl 0x1001 and swr 0x1002 paired
        tick();
        g.a = mk(5'b00010, 7'b0, 32'h0000_1001, 32'h1122_3344);
        g.b = mk(5'b00001, 7'b0, 32'h0000_1002, 32'h1122_3344);
        g.v2 = 1'b1;
        drive(g, 1'b1);
        tick(); drive(idle, 1'b0); #3;
        chk("lit_swl_wstrb", st01, 4'b0011);
        chk("lit_swl_wdata", wd01, 32'h0000_1122);
        chk("lit_swr_wstrb", st02, 4'b1100);
        chk("lit_swr_wdata", wd02, 32'h3344_0000);

        // lw + sb 0x2003 held for three cycles
        tick();
        ok_mode = 2;
        g.a = mk(5'b0, 7'b0000100, 32'h0000_3000, 32'h0);
        g.b = mk(5'b10000, 7'b0, 32'h0000_2003, 32'h0000_005A);
        g.v2 = 1'b1;
        drive(g, 1'b1);
        tick(); drive(idle, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #3;
            chk("lit_hold_v01", v01, 1'b1);
            chk("lit_hold_v02", v02, 1'b1);
            chk("lit_hold_tv", pms_to_ms_valid, 1'b0);
            chk("lit_hold_addr01", ad01, 32'h0000_3000);
            chk("lit_hold_addr02", ad02, 32'h0000_2000);
            chk("lit_sb_wstrb", st02, 4'b1000);
            chk("lit_sb_wdata", wd02, 32'h5A5A_5A5A);
            tick();
        end
        ok_mode = 1;
        #3;
        chk("lit_hold_release", pms_to_ms_valid, 1'b1);

        // MEM blocked with a load pending
        tick();
        g = idle; g.a = mk(5'b0, 7'b0000100, 32'h0000_4000, 32'h0);
        drive(g, 1'b1);
        tick(); drive(idle, 1'b0); ms_allowin = 1'b0; #3;
        chk("lit_blk_v01", v01, 1'b0);
        chk("lit_blk_allowin", pms_allowin, 1'b0);
        tick(); ms_allowin = 1'b1; #3;
        chk("lit_unblk_v01", v01, 1'b1);
        chk("lit_unblk_tv", pms_to_ms_valid, 1'b1);

        // slot 2 store marked invalid
        tick();
        g = idle;
        g.a = mk(5'b0, 7'b0000100, 32'h0000_5000, 32'h0);
        g.b = mk(5'b00100, 7'b0, 32'h0000_5004, 32'h1234_5678);
        g.v2 = 1'b0;
        drive(g, 1'b1);
        tick(); drive(idle, 1'b0); #3;
        chk("lit_inv2_v02", v02, 1'b0);
        chk("lit_inv2_v01", v01, 1'b1);
        chk("lit_inv2_tv", pms_to_ms_valid, 1'b1);

        // reset while a request is pending
        tick();
        ok_mode = 2;
        g = idle; g.a = mk(5'b0, 7'b0000100, 32'h0000_6000, 32'h0);
        drive(g, 1'b1);
        tick(); drive(idle, 1'b0); #3;
        chk("lit_pend_v01", v01, 1'b1);
        tick(); reset = 1'b1; #3;
        chk("lit_rstcyc_v01", v01, 1'b0);
        tick(); reset = 1'b0; #3;
        chk("lit_after_rst_fwd", fwd_bus[78], 1'b0);
        chk("lit_after_rst_v01", v01, 1'b0);
        chk("lit_after_rst_allowin", pms_allowin, 1'b1);

        // random traffic
        ok_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 199) == 0);
            ms_allowin = ($urandom_range(0, 3) != 0);
            g.a = rnd_inst();
            g.b = rnd_inst();
            g.v2 = 1'($urandom_range(0, 1));
            drive(g, 1'($urandom_range(0, 2) != 0));
        end
        tick();
        reset = 1'b0;
        ms_allowin = 1'b1;
        drive(idle, 1'b0);
        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
